// File: rtl/csi2_frame_cropper.sv
// CSI-2 RAW8 frame cropper: forwards IMAGE_WIDTH x IMAGE_HEIGHT pixels per frame from a
// 4-pixel-per-word payload stream, dropping excess words, zero-padding short lines and
// flagging short lines/frames. All outputs are registered.
module csi2_frame_cropper #(
  parameter int unsigned IMAGE_WIDTH  = 640,
  parameter int unsigned IMAGE_HEIGHT = 480
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_start,
  input  logic        frame_end,
  input  logic        in_enable,
  input  logic [31:0] in_data,      // lane 0 (earliest pixel) in [7:0]
  input  logic        packet_end,
  output logic        out_enable,
  output logic [31:0] out_data,     // same lane order as in_data
  output logic        out_frame_start,
  output logic        frame_complete,
  output logic        short_line,
  output logic        short_frame
);

  localparam int unsigned Wpl   = IMAGE_WIDTH / 4;
  localparam int unsigned ColW  = $clog2(Wpl + 1);
  localparam int unsigned LineW = $clog2(IMAGE_HEIGHT + 1);

  localparam logic [ColW-1:0]  WplCol     = ColW'(Wpl);
  localparam logic [ColW-1:0]  OneCol     = ColW'(1);
  localparam logic [LineW-1:0] HeightLine = LineW'(IMAGE_HEIGHT);

  typedef enum logic [2:0] {
    StWaitFs,
    StWaitLine,
    StLine,
    StDiscard,
    StPad,
    StFrameFull
  } state_e;

  state_e           state_q, state_d;
  logic [ColW-1:0]  col_q, col_d;
  logic [LineW-1:0] line_q, line_d;

  logic             out_enable_q, out_enable_d;
  logic [31:0]      out_data_q, out_data_d;
  logic             out_frame_start_q, out_frame_start_d;
  logic             last_q, last_d;           // marks the final word of the frame
  logic             frame_complete_q;
  logic             short_line_q, short_line_d;
  logic             short_frame_q, short_frame_d;

  logic [ColW-1:0]  col_inc;
  logic [LineW-1:0] line_inc;

  assign col_inc  = col_q + OneCol;
  assign line_inc = line_q + LineW'(1);

  // Next-state, counter and output-register decode; frame_start has top priority.
  always_comb begin
    state_d           = state_q;
    col_d             = col_q;
    line_d            = line_q;
    out_enable_d      = 1'b0;
    out_data_d        = out_data_q;
    out_frame_start_d = 1'b0;
    last_d            = 1'b0;
    short_line_d      = short_line_q;
    short_frame_d     = short_frame_q;

    if (frame_start) begin
      state_d           = StWaitLine;
      col_d             = '0;
      line_d            = '0;
      out_frame_start_d = 1'b1;
      if (state_q == StWaitFs) begin
        short_line_d  = 1'b0;
        short_frame_d = 1'b0;
      end else if (line_q < HeightLine) begin
        short_frame_d = 1'b1;
      end
    end else if (frame_end && (state_q != StWaitFs)) begin
      // A partial line is abandoned, never completed.
      state_d = StWaitFs;
      if ((state_q != StFrameFull) && (line_q < HeightLine)) begin
        short_frame_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        StWaitFs: begin
          // All payload dropped until a frame starts.
        end
        StWaitLine: begin
          if (in_enable && !packet_end) begin
            out_enable_d = 1'b1;
            out_data_d   = in_data;
            if (OneCol == WplCol) begin
              col_d   = '0;
              line_d  = line_inc;
              last_d  = (line_inc == HeightLine);
              state_d = StDiscard;
            end else begin
              col_d   = OneCol;
              state_d = StLine;
            end
          end
        end
        StLine: begin
          // packet_end with in_enable is illegal; the word is dropped.
          if (packet_end) begin
            state_d = StPad;
          end else if (in_enable) begin
            out_enable_d = 1'b1;
            out_data_d   = in_data;
            if (col_inc == WplCol) begin
              col_d   = '0;
              line_d  = line_inc;
              last_d  = (line_inc == HeightLine);
              state_d = StDiscard;
            end else begin
              col_d = col_inc;
            end
          end
        end
        StDiscard: begin
          if (packet_end) begin
            state_d = (line_q == HeightLine) ? StFrameFull : StWaitLine;
          end
        end
        StPad: begin
          out_enable_d = 1'b1;
          out_data_d   = '0;
          if (in_enable) begin
            short_line_d = 1'b1;
          end
          if (col_inc == WplCol) begin
            col_d        = '0;
            line_d       = line_inc;
            last_d       = (line_inc == HeightLine);
            short_line_d = 1'b1;
            state_d      = (line_inc == HeightLine) ? StFrameFull : StWaitLine;
          end else begin
            col_d = col_inc;
          end
        end
        StFrameFull: begin
          // Payload beyond the last line is dropped; frame_end handled above.
        end
        default: begin
          state_d = StWaitFs;
        end
      endcase
    end
  end

  // Control state and counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StWaitFs;
      col_q   <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      line_q  <= line_d;
    end
  end

  // Registered outputs; frame_complete trails the final word by one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_enable_q      <= 1'b0;
      out_data_q        <= '0;
      out_frame_start_q <= 1'b0;
      last_q            <= 1'b0;
      frame_complete_q  <= 1'b0;
      short_line_q      <= 1'b0;
      short_frame_q     <= 1'b0;
    end else begin
      out_enable_q      <= out_enable_d;
      out_data_q        <= out_data_d;
      out_frame_start_q <= out_frame_start_d;
      last_q            <= last_d;
      frame_complete_q  <= last_q;
      short_line_q      <= short_line_d;
      short_frame_q     <= short_frame_d;
    end
  end

  assign out_enable      = out_enable_q;
  assign out_data        = out_data_q;
  assign out_frame_start = out_frame_start_q;
  assign frame_complete  = frame_complete_q;
  assign short_line      = short_line_q;
  assign short_frame     = short_frame_q;

endmodule

// File: doc/csi2_frame_cropper.md
CSI2_FRAME_CROPPER -- requirements
Module: csi2_frame_cropper

Interface
REQ-001 SHALL have parameter IMAGE_WIDTH, default 640, giving pixels per output line; it must be a multiple of 4.
REQ-002 SHALL have parameter IMAGE_HEIGHT, default 480, giving lines per output frame.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  byte-clock from the CSI-2 receiver; all logic is clocked on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 frame_start  input  1  one-cycle pulse on a decoded FS short packet.
REQ-007 frame_end  input  1  one-cycle pulse on a decoded FE short packet.
REQ-008 in_enable  input  1  RAW8 long-packet payload word valid (4 pixels).
REQ-009 in_data  input  8 x [0:3]  payload bytes; lane 0 is the earliest pixel.
REQ-010 packet_end  input  1  one-cycle pulse on the cycle after the last payload word of a long packet.
REQ-011 out_enable  output  1  output word valid.
REQ-012 out_data  output  8 x [0:3]  output pixels, in the same lane order as in_data.
REQ-013 out_frame_start  output  1  one-cycle pulse preceding the first out_enable of a frame.
REQ-014 frame_complete  output  1  one-cycle pulse after the last word of line IMAGE_HEIGHT-1.
REQ-015 short_line  output  1  sticky flag: a line was padded, or input was dropped during padding.
REQ-016 short_frame  output  1  sticky flag: FE or FS arrived before IMAGE_HEIGHT lines were emitted.

Function
REQ-017 Derived constant: WPL = IMAGE_WIDTH/4. The column counter counts 0..WPL-1; the line counter counts 0..IMAGE_HEIGHT.
REQ-018 All outputs SHALL be registered, with one cycle of latency from in_enable to out_enable.
REQ-019 out_data SHALL change only on cycles where out_enable is asserted, and SHALL hold its value otherwise.
REQ-020 The block SHALL have these states: WAIT_FS, WAIT_LINE, LINE, DISCARD, PAD, FRAME_FULL.
REQ-021 WAIT_FS: all input is dropped; on frame_start, go to WAIT_LINE, clear both counters and both sticky flags, and pulse out_frame_start next cycle.
REQ-022 WAIT_LINE: on in_enable, forward the word, set col=1, and go to LINE.
REQ-023 LINE: each in_enable forwards one word and increments col; on the word where col reaches WPL, go to DISCARD with line+1.
REQ-024 LINE with packet_end and col<WPL: go to PAD.
REQ-025 DISCARD: drop in_enable words; on packet_end, go to WAIT_LINE, or to FRAME_FULL if line==IMAGE_HEIGHT.
REQ-026 PAD: emit out_enable with all-zero out_data once per cycle until col reaches WPL, then set short_line, line+1, and next state as in REQ-025.
REQ-027 PAD: any in_enable during PAD SHALL be dropped and SHALL set short_line.
REQ-028 On reaching line==IMAGE_HEIGHT, the block SHALL pulse frame_complete once, on the cycle after the final output word.
REQ-029 FRAME_FULL: drop all payload; on frame_end, go to WAIT_FS.
REQ-030 frame_end in WAIT_LINE, LINE, DISCARD or PAD SHALL set short_frame and go to WAIT_FS; a partial line is not completed.
REQ-031 frame_start in any state other than WAIT_FS SHALL restart the frame as in REQ-021. short_frame SHALL be set if line<IMAGE_HEIGHT.
REQ-032 frame_start SHALL take priority over frame_end, packet_end and in_enable in the same cycle.
REQ-033 A frame_start that restarts a frame SHALL not clear short_frame in that cycle; the flags clear only on a frame_start taken from WAIT_FS.
REQ-034 packet_end together with in_enable in the same cycle is illegal input; the in_enable word SHALL be dropped.
REQ-035 A complete frame SHALL produce exactly WPL*IMAGE_HEIGHT out_enable cycles.

Reset
REQ-036 On reset_n low, the block SHALL enter WAIT_FS and clear col and line, asynchronously.
REQ-037 On reset_n low, out_enable, out_frame_start, frame_complete, short_line and short_frame SHALL be 0, and out_data SHALL be all-zero.
REQ-038 A reset during LINE or PAD SHALL abandon the frame; no padding resumes after reset_n is released.

Verification (with IMAGE_WIDTH=16, IMAGE_HEIGHT=3, so WPL=4)
REQ-039 Stimulus: FS, then 3 lines of 6 words each, then FE. Required: out_frame_start once; 12 out_enable cycles; words 5-6 of each line dropped; frame_complete once; both flags 0.
REQ-040 Stimulus: FS, then a line of 2 words followed by packet_end. Required: 2 data words, then 2 zero words on consecutive cycles; short_line=1; line counter advances.
REQ-041 Stimulus: in_enable asserted before any FS after reset. Required: no out_enable; state stays WAIT_FS.
REQ-042 Stimulus: FS, 1 full line, then FE. Required: 4 out_enable cycles; short_frame=1; no frame_complete; next FS clears short_frame.
REQ-043 Stimulus: FS and FE pulsed on the same cycle while in LINE. Required: restart behaviour per REQ-031; short_frame=1; next line's out_enable count restarts at col 0.
REQ-044 Stimulus: reset_n pulsed low during PAD. Required: all outputs 0 immediately; no zero words after release.
